// File: rtl/alarm_if.sv
// Request/control and status bundle between the alarm_scheduler
// and its requesters, the ack debouncer and the output pins.
interface alarm_if #(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = 5
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         cancel;
  logic [N_REQ*DELAY_W-1:0] delay;
  logic                     ack_n;
  logic [N_REQ-1:0]         pending;
  logic                     busy;
  logic [IW-1:0]            active_id;
  logic [DELAY_W-1:0]       count;
  logic                     alert;

  modport master (
    output req, cancel, delay, ack_n,
    input  pending, busy, active_id,
    input  count, alert
  );

  modport slave (
    input  req, cancel, delay, ack_n,
    output pending, busy, active_id,
    output count, alert
  );
endinterface

// File: rtl/alarm_scheduler.sv
// Round-robin sharing of one countdown timer and one alert
// output among N_REQ alarm requesters.
module alarm_scheduler #(
  parameter int N_REQ    = 4,
  parameter int DELAY_W  = 5,
  parameter int PRESCALE = 4
) (
  input logic    clk,
  input logic    rst_n,
  alarm_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ALERT
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [N_REQ-1:0]   pend_q;
  logic [N_REQ-1:0]   pend_nx;
  logic [N_REQ-1:0]   grant;
  logic [IW-1:0]      rr_q;
  logic [IW-1:0]      rr_nx;
  logic [IW-1:0]      id_q;
  logic [IW-1:0]      id_nx;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      idx;
  logic [DELAY_W-1:0] cnt_q;
  logic [DELAY_W-1:0] cnt_nx;
  logic [PW-1:0]      pre_q;
  logic [PW-1:0]      pre_nx;
  logic               found;
  logic               abort;

  // First pending bit at or above rr_q; index wraps mod N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    idx   = rr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_q + IW'(k);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign abort = bus.cancel[id_q];

  always_comb begin
    state_nx = state;
    rr_nx    = rr_q;
    id_nx    = id_q;
    cnt_nx   = cnt_q;
    pre_nx   = pre_q;
    grant    = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant[pick] = 1'b1;
          id_nx       = pick;
          rr_nx       = pick + 1'b1;
          cnt_nx      =
            bus.delay[32'(pick)*DELAY_W +: DELAY_W];
          pre_nx      = '0;
          state_nx    = COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (cnt_q == '0) begin
          state_nx = ALERT;
        end else if (pre_q == PRE_LAST) begin
          pre_nx = '0;
          cnt_nx = cnt_q - 1'b1;
        end else begin
          pre_nx = pre_q + 1'b1;
        end
      end
      ALERT: begin
        if (abort || !bus.ack_n) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    pend_nx = (pend_q | bus.req)
            & ~bus.cancel & ~grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend_q <= '0;
      rr_q   <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
      pre_q  <= '0;
    end else begin
      state  <= state_nx;
      pend_q <= pend_nx;
      rr_q   <= rr_nx;
      id_q   <= id_nx;
      cnt_q  <= cnt_nx;
      pre_q  <= pre_nx;
    end
  end

  assign bus.pending   = pend_q;
  assign bus.busy      = (state != IDLE);
  assign bus.active_id = id_q;
  assign bus.count     = cnt_q;
  assign bus.alert     = (state == ALERT);
endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Sequences one shared countdown timer and one alert output among `N_REQ` alarm requesters. Requests are queued, granted round-robin, and timed for a per-channel delay. The granted channel's alert is then held until the user acknowledges it with the active-low one-cycle pulse from the button debouncer. The block sits between the debounced button/control inputs and the top-level `uo_out`/`uio_out` pins, replacing the single hard-wired alarm FSM.

## Interface
- `N_REQ`, 4: number of requesters; index width `IW = 2`. Fixed at 4 in this revision.
- `DELAY_W`, 5: width of each per-channel delay and of the countdown.
- `PRESCALE`, 4: clk cycles per countdown tick; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  one-cycle request pulses; bit i high sets `pending[i]`.
- `cancel`  in  N_REQ  bit i high clears `pending[i]` and aborts channel i if it is active.
- `delay`  in  N_REQ*DELAY_W  per-channel delay in ticks; channel i occupies bits [i*DELAY_W +: DELAY_W]; sampled at grant only.
- `ack_n`  in  1  active-low acknowledge pulse from the debouncer.
- `pending`  out  N_REQ  queued, not-yet-granted requests.
- `busy`  out  1  high when not IDLE.
- `active_id`  out  IW  channel that owns the timer; holds last value while IDLE.
- `count`  out  DELAY_W  remaining ticks of the active channel.
- `alert`  out  1  high only in ALERT.

## Operation
- FSM states: IDLE, COUNT, ALERT.
- **IDLE:**
  - If `pending != 0`, grant the first set bit searching upward from `rr_ptr` with wrap-around.
  - On grant: clear that `pending` bit, set `active_id`, load `count = delay[id]`, clear the prescaler, and go to COUNT.
  - After each grant, `rr_ptr = id + 1` (mod N_REQ).
- **COUNT:**
  - If `count == 0`, go to ALERT next cycle.
  - Otherwise the prescaler runs from 0 to PRESCALE-1. On each wrap (tick), `count` decrements by 1.
  - `ack_n` is ignored in this state.
- **ALERT:**
  - `alert = 1`.
  - `ack_n` sampled low: go to IDLE next cycle; `count` stays 0.
- **Cancel:**
  - In COUNT or ALERT, `cancel[active_id]` high: go to IDLE next cycle; `alert` drops with the state.
  - Cancels of other channels only clear their `pending` bits.
- **Pending update per cycle:** `pending_next = (pending | req) & ~cancel & ~grant_onehot`.
  - `req` and `cancel` high on the same bit in the same cycle: cancel wins.
  - A `req` on the currently active channel re-queues it and does not disturb the current run.
- A grant in IDLE considers only `pending` as registered. A `req` arriving in the same cycle is visible one cycle later.
- Arithmetic is unsigned. `count` never underflows because a decrement happens only when `count != 0`.
- **Reset (async assert, sync release):** state IDLE, `pending = 0`, `rr_ptr = 0`, `active_id = 0`, `count = 0`, prescaler 0, `busy = 0`, `alert = 0`.
- Reset mid-operation discards all queued and active alarms.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- **Grant latency:** `pending[i]` set at edge t → IDLE grant at edge t+1. At that edge `busy` rises and `pending[i]` clears.
- **Alert latency:** grant edge g, delay D → `count` reaches 0 at edge g + D*PRESCALE → `alert` rises at edge g + D*PRESCALE + 1.
  - D = 0: `alert` rises at g + 1.
- **Ack:** `ack_n` low sampled at edge a → `alert` and `busy` fall at edge a.
  - A further pending request is granted at edge a+1; there is a minimum one IDLE cycle between alarms.
- **Cancel:** `cancel[active_id]` sampled at edge c → `busy` and `alert` fall at edge c.

## Test plan
- **Reset:** assert `rst_n = 0` mid-COUNT, with no clock edge during assertion → immediately `busy = 0`, `alert = 0`, `pending = 0`, `count = 0`.
- **Single alarm:** PRESCALE = 4, `delay[2] = 3`, pulse `req[2]` → `busy` rises one edge later and `active_id = 2`. `count` steps 3, 2, 1, 0 every 4 cycles. `alert` rises 13 cycles after the grant. A one-cycle `ack_n = 0` drops `alert`.
- **Round-robin:**
  - `req = 4'b1111` in one cycle, all delays 0 → grants in order 0, 1, 2, 3, each after ack.
  - After granting 1, new `req[0]` and `req[2]` → channel 2 is granted before channel 0.
- **Cancel:**
  - `cancel[active_id]` during COUNT with `count = 5` → IDLE next edge; no alert.
  - Same-cycle `req[3]` and `cancel[3]` → `pending[3]` stays 0.
- **Ignore ack and re-queue:** `ack_n = 0` pulse while in COUNT → no effect; `alert` still asserts on schedule. `req[active_id]` during COUNT → `pending` bit set, channel re-granted after ack.
- **Boundary:** `delay = 31` (max) with PRESCALE = 1 → `alert` at grant + 32. `delay = 0` → `alert` at grant + 1.
